// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide engine that answers the
// control unit's start/done handshake for MULT and DIV instructions.
//
// Handshake: a request is accepted on any rising edge where start = 1 and
// the unit is in IDLE. busy is high from the next cycle through the DONE
// cycle inclusive. done pulses for exactly one cycle, and hi_out/lo_out are
// valid from that cycle on. A start seen in any other state is dropped; it is
// not queued.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-high; overrides everything, including an
//             operation in flight
//   start   - request pulse, sampled only in IDLE
//   op      - 0 = MULT, 1 = DIV, sampled with start
//   a_in    - signed multiplicand / dividend, sampled with start
//   b_in    - signed multiplier / divisor, sampled with start
//   busy    - operation in progress (includes the DONE cycle)
//   done    - one-cycle completion pulse
//   div0    - DIV had a zero divisor; held until the next accepted start
//   hi_out  - MULT: upper product word, DIV: remainder
//   lo_out  - MULT: lower product word, DIV: quotient
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mag;       // MULT: |multiplicand|, DIV: |divisor|
    logic [WIDTH-1:0] work_hi;   // MULT: upper partial product, DIV: remainder
    logic [WIDTH-1:0] work_lo;   // MULT: multiplier bits / lower product, DIV: dividend -> quotient
    logic             sign_a;
    logic             sign_neg;

    logic             accept;
    logic             last_step;
    logic             b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;
    logic [WIDTH-1:0]   quo_signed, rem_signed;

    assign accept    = (state == S_IDLE) && start;
    assign last_step = (count == CW'(WIDTH - 1));
    assign b_zero    = (b_in == '0);

    // The magnitude of the most-negative value is 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit number.
    assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!op)        state_next = S_MULT;
                    else if (b_zero) state_next = S_DONE;
                    else            state_next = S_DIV;
                end
            end
            S_MULT:  if (last_step) state_next = S_DONE;
            S_DIV:   if (last_step) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // One iteration of shift-add or restoring division.
    always_comb begin
        add_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag} : '0);
        shifted = {work_hi, work_lo[WIDTH-1]};
        diff    = shifted - {1'b0, mag};
        step_hi = work_hi;
        step_lo = work_lo;
        if (state == S_MULT) begin
            // The carry out of the add shifts down into the upper word.
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], work_lo[WIDTH-1:1]};
        end else if (state == S_DIV) begin
            // A borrow out of the trial subtract means the divisor did not fit.
            if (!diff[WIDTH]) begin
                step_hi = diff[WIDTH-1:0];
                step_lo = {work_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {work_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction applied to the result of the final iteration.
    always_comb begin
        prod_mag    = {step_hi, step_lo};
        prod_signed = sign_neg ? -prod_mag : prod_mag;
        quo_signed  = sign_neg ? -step_lo : step_lo;
        rem_signed  = sign_a ? -step_hi : step_hi;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            mag      <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            sign_a   <= 1'b0;
            sign_neg <= 1'b0;
            div0     <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else if (accept) begin
            count    <= '0;
            sign_a   <= a_in[WIDTH-1];
            sign_neg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            div0     <= op & b_zero;
            work_hi  <= '0;
            if (op) begin
                mag     <= b_mag;
                work_lo <= a_mag;
            end else begin
                mag     <= a_mag;
                work_lo <= b_mag;
            end
        end else if (state == S_MULT || state == S_DIV) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            count   <= count + 1'b1;
            if (last_step) begin
                if (state == S_MULT) begin
                    {hi_out, lo_out} <= prod_signed;
                end else begin
                    hi_out <= rem_signed;
                    lo_out <= quo_signed;
                end
            end
        end
    end

endmodule
